// File: rtl/simt_reconv_scheduler_pkg.sv
// Shared types and constants for the SIMT reconvergence scheduler.
// Optional statistics outputs are enabled with SIMT_SCHED_STATS_EN.
package gpu_sched_pkg;
  localparam int SCHED_THREADS     = 4;
  localparam int SCHED_ADDR_BITS   = 8;
  localparam int SCHED_STACK_DEPTH = 4;

  localparam logic [2:0] N = 3'b100;
  localparam logic [2:0] Z = 3'b010;
  localparam logic [2:0] P = 3'b001;

  // One divergence frame: mask to restore at reconvergence plus the parked path.
  typedef struct packed {
    logic [SCHED_THREADS-1:0]   saved_mask;
    logic [SCHED_THREADS-1:0]   pend_mask;
    logic [SCHED_ADDR_BITS-1:0] pend_pc;
    logic                       pend_vld;
  } reconv_entry_t;
endpackage

// File: rtl/simt_reconv_scheduler_if.sv
// Core-side bus of the SIMT reconvergence scheduler (fetch/decode in, mask/PC out).
// Statistics signals exist only with SIMT_SCHED_STATS_EN.
interface simt_reconv_scheduler_if #(
  parameter int T = 4,
  parameter int A = 8,
  parameter int D = 4
);
  logic                   launch;
  logic [$clog2(T):0]     thread_count;
  logic                   exec_valid;
  logic                   is_branch;
  logic                   is_sync;
  logic [2:0]             condition;
  logic [7:0]             imm8;
  logic [A-1:0]           pc;
  logic [T-1:0][2:0]      nzp;
  logic [T-1:0]           active_threads;
  logic [A-1:0]           next_pc;
  logic                   load_pc;
  logic [$clog2(D):0]     stack_depth;
  logic                   overflow;
`ifdef SIMT_SCHED_STATS_EN
  logic [15:0]            div_count;
  logic [$clog2(D):0]     max_depth;

  modport master (
    output launch, thread_count, exec_valid, is_branch, is_sync, condition, imm8, pc, nzp,
    input  active_threads, next_pc, load_pc, stack_depth, overflow, div_count, max_depth
  );
  modport slave (
    input  launch, thread_count, exec_valid, is_branch, is_sync, condition, imm8, pc, nzp,
    output active_threads, next_pc, load_pc, stack_depth, overflow, div_count, max_depth
  );
`else
  modport master (
    output launch, thread_count, exec_valid, is_branch, is_sync, condition, imm8, pc, nzp,
    input  active_threads, next_pc, load_pc, stack_depth, overflow
  );
  modport slave (
    input  launch, thread_count, exec_valid, is_branch, is_sync, condition, imm8, pc, nzp,
    output active_threads, next_pc, load_pc, stack_depth, overflow
  );
`endif
endinterface

// File: rtl/simt_reconv_scheduler_stack.sv
// LIFO of reconvergence frames; push/pop/wr_top are mutually exclusive, clr wins.
module simt_stack
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     wr_top,
  input  reconv_entry_t            push_data,
  output reconv_entry_t            top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  reconv_entry_t   mem [DEPTH];
  logic [DW-1:0]   cnt;
  logic [IW-1:0]   top_idx, wr_idx;

  assign top_idx = IW'(cnt - 1'b1);
  assign wr_idx  = IW'(cnt);
  assign top     = mem[top_idx];
  assign depth   = cnt;
  assign full    = (cnt == DW'(DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      cnt         <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end else if (wr_top && !empty) begin
      mem[top_idx].pend_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/simt_reconv_scheduler.sv
// SIMT branch scheduler with divergence/reconvergence stack; drives mask, next_pc, load_pc.
// Define SIMT_SCHED_STATS_EN to add div_count/max_depth statistics outputs.
module simt_reconv_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = SCHED_THREADS,
  parameter int PROGRAM_MEM_ADDR_BITS = SCHED_ADDR_BITS,
  parameter int STACK_DEPTH           = SCHED_STACK_DEPTH
) (
  input logic                clk,
  input logic                reset,
  simt_reconv_scheduler_if.slave bus
);
  localparam int T   = THREADS_PER_BLOCK;
  localparam int A   = PROGRAM_MEM_ADDR_BITS;
  localparam int DW  = $clog2(STACK_DEPTH) + 1;
  localparam int TCW = $clog2(T) + 1;

  logic [T-1:0]  active, active_d, taken, launch_mask;
  logic [A-1:0]  next_pc, npc_d, pc_inc, target;
  logic          load_pc, load_d, overflow, ovf_d;
  logic          push, pop, wr_top, full, empty, ev;
  logic [DW-1:0] depth;
  reconv_entry_t top, push_ent;

  for (genvar t = 0; t < T; t++) begin : g_lane
    assign taken[t]       = active[t] & |(bus.nzp[t] & bus.condition);
    assign launch_mask[t] = (TCW'(t) < bus.thread_count);
  end

  assign pc_inc = bus.pc + 1'b1;
  assign target = bus.pc + A'($signed(bus.imm8));
  assign ev     = bus.exec_valid & ~bus.launch;

  always_comb begin
    push_ent            = '0;
    push_ent.saved_mask = active;
    push_ent.pend_mask  = active & ~taken;
    push_ent.pend_pc    = pc_inc;
    push_ent.pend_vld   = 1'b1;
  end

  // Branch beats SYNC when both are flagged; a full stack degrades divergence to not-taken.
  always_comb begin
    active_d = active;
    npc_d    = pc_inc;
    load_d   = 1'b0;
    ovf_d    = overflow;
    push     = 1'b0;
    pop      = 1'b0;
    wr_top   = 1'b0;
    if (ev && bus.is_branch) begin
      if (taken == active) begin
        npc_d  = target;
        load_d = 1'b1;
      end else if (taken != '0) begin
        if (!full) begin
          push     = 1'b1;
          active_d = taken;
          npc_d    = target;
          load_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else if (ev && bus.is_sync && !empty) begin
      load_d = 1'b1;
      if (top.pend_vld) begin
        active_d = top.pend_mask;
        npc_d    = top.pend_pc;
        wr_top   = 1'b1;
      end else begin
        active_d = top.saved_mask;
        pop      = 1'b1;
      end
    end
  end

  simt_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.launch),
    .push      (push),
    .pop       (pop),
    .wr_top    (wr_top),
    .push_data (push_ent),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= '0;
      next_pc  <= '0;
      load_pc  <= 1'b0;
      overflow <= 1'b0;
    end else if (bus.launch) begin
      active   <= launch_mask;
      next_pc  <= pc_inc;
      load_pc  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      active   <= active_d;
      next_pc  <= npc_d;
      load_pc  <= load_d;
      overflow <= ovf_d;
    end
  end

  assign bus.active_threads = active;
  assign bus.next_pc        = next_pc;
  assign bus.load_pc        = load_pc;
  assign bus.stack_depth    = depth;
  assign bus.overflow       = overflow;

`ifdef SIMT_SCHED_STATS_EN
  logic [15:0]   div_count;
  logic [DW-1:0] max_depth;
  logic          diverge;

  assign diverge = ev & bus.is_branch & (taken != active) & (taken != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_count <= '0;
      max_depth <= '0;
    end else if (bus.launch) begin
      div_count <= '0;
      max_depth <= '0;
    end else begin
      if (diverge && div_count != 16'hFFFF) div_count <= div_count + 1'b1;
      if (push && DW'(depth + 1'b1) > max_depth) max_depth <= DW'(depth + 1'b1);
    end
  end

  assign bus.div_count = div_count;
  assign bus.max_depth = max_depth;
`endif
endmodule

// File: tb/tb_simt_reconv_scheduler.sv
// Bench for simt_reconv_scheduler: directed vector table, hand corner cases, random vs model.
module tb_simt_reconv_scheduler;
  import gpu_sched_pkg::*;
  localparam int T = 4;
  localparam int A = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  simt_reconv_scheduler_if #(.T(T), .A(A), .D(D)) bus();
  simt_reconv_scheduler #(
    .THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A), .STACK_DEPTH(D)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: a queue of frames and the current mask.
  typedef struct {
    logic [T-1:0] saved;
    logic [T-1:0] pend;
    logic [A-1:0] ppc;
    bit           vld;
  } ment_t;
  ment_t        stk[$];
  logic [T-1:0] m_act;
  logic [A-1:0] m_npc;
  bit           m_load, m_ovf;
  int           m_div, m_max;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    stk.delete();
    m_act = '0; m_npc = '0; m_load = 0; m_ovf = 0; m_div = 0; m_max = 0;
  endtask

  task automatic model_step(bit lch, int tc, bit ev, bit br, bit sy, logic [2:0] cond,
                            logic [7:0] imm, logic [A-1:0] pcv, logic [T*3-1:0] nz);
    logic [T-1:0] tk;
    ment_t        e;
    m_npc  = A'(int'(pcv) + 1);
    m_load = 0;
    if (lch) begin
      m_act = T'((1 << tc) - 1);
      stk.delete();
      m_ovf = 0; m_div = 0; m_max = 0;
      return;
    end
    if (ev && br) begin
      tk = '0;
      for (int t = 0; t < T; t++)
        if (m_act[t] && (nz[t*3 +: 3] & cond) != 3'b000) tk[t] = 1'b1;
      if (tk == m_act) begin
        m_npc  = A'(int'(pcv) + int'($signed(imm)));
        m_load = 1;
      end else if (tk != '0) begin
        if (m_div < 65535) m_div++;
        if (stk.size() < D) begin
          e.saved = m_act; e.pend = m_act & ~tk; e.ppc = A'(int'(pcv) + 1); e.vld = 1;
          stk.push_back(e);
          if (stk.size() > m_max) m_max = stk.size();
          m_act  = tk;
          m_npc  = A'(int'(pcv) + int'($signed(imm)));
          m_load = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end else if (ev && sy && stk.size() > 0) begin
      m_load = 1;
      if (stk[$].vld) begin
        m_act = stk[$].pend;
        m_npc = stk[$].ppc;
        stk[$].vld = 0;
      end else begin
        e = stk.pop_back();
        m_act = e.saved;
      end
    end
  endtask

  task automatic cycle(string nm, bit lch, int tc, bit ev, bit br, bit sy, logic [2:0] cond,
                       logic [7:0] imm, logic [A-1:0] pcv, logic [T*3-1:0] nz);
    bus.launch = lch; bus.thread_count = 3'(tc); bus.exec_valid = ev;
    bus.is_branch = br; bus.is_sync = sy; bus.condition = cond;
    bus.imm8 = imm; bus.pc = pcv; bus.nzp = nz;
    model_step(lch, tc, ev, br, sy, cond, imm, pcv, nz);
    @(posedge clk); #1;
    bus.launch = 0; bus.exec_valid = 0;
    chk({nm, ".mask"},  32'(bus.active_threads), 32'(m_act));
    chk({nm, ".npc"},   32'(bus.next_pc),        32'(m_npc));
    chk({nm, ".load"},  32'(bus.load_pc),        32'(m_load));
    chk({nm, ".depth"}, 32'(bus.stack_depth),    32'(stk.size()));
    chk({nm, ".ovf"},   32'(bus.overflow),       32'(m_ovf));
`ifdef SIMT_SCHED_STATS_EN
    chk({nm, ".divc"},  32'(bus.div_count),      32'(m_div));
    chk({nm, ".maxd"},  32'(bus.max_depth),      32'(m_max));
`endif
  endtask

  task automatic launch_blk(int tc);
    cycle("launch", 1, tc, 0, 0, 0, 3'b0, 8'h0, 8'h0, '0);
  endtask

  typedef struct {
    bit           lch;
    int           tc;
    bit           br, sy;
    logic [2:0]   cond;
    logic [7:0]   imm;
    logic [A-1:0] pcv;
    logic [11:0]  nz;
    logic [T-1:0] e_act;
    logic [A-1:0] e_npc;
    bit           e_load;
    int           e_dep;
  } vec_t;
  vec_t vt[9];

  localparam logic [11:0] ALLP = {P, P, P, P};

  initial begin
    vt[0] = '{1, 3, 1, 0, P, 8'd5,   8'd10,  ALLP,         4'b0111, 8'd15,  1, 0};
    vt[1] = '{1, 4, 1, 0, P, 8'hFC,  8'd20,  {N, N, P, P}, 4'b0011, 8'd16,  1, 1};
    vt[2] = '{0, 0, 0, 1, P, 8'd0,   8'd30,  ALLP,         4'b1100, 8'd21,  1, 1};
    vt[3] = '{0, 0, 0, 1, P, 8'd0,   8'd30,  ALLP,         4'b1111, 8'd31,  1, 0};
    vt[4] = '{0, 0, 0, 1, P, 8'd0,   8'd40,  ALLP,         4'b1111, 8'd41,  0, 0};
    vt[5] = '{1, 4, 1, 0, P, 8'd4,   8'hFE,  ALLP,         4'b1111, 8'h02,  1, 0};
    vt[6] = '{1, 4, 1, 0, Z, 8'd9,   8'd50,  ALLP,         4'b1111, 8'd51,  0, 0};
    vt[7] = '{0, 0, 1, 1, P, 8'd2,   8'd60,  ALLP,         4'b1111, 8'd62,  1, 0};
    vt[8] = '{1, 0, 1, 0, P, 8'd3,   8'd70,  ALLP,         4'b0000, 8'd73,  1, 0};

    bus.launch = 0; bus.thread_count = '0; bus.exec_valid = 0; bus.is_branch = 0;
    bus.is_sync = 0; bus.condition = '0; bus.imm8 = '0; bus.pc = '0; bus.nzp = '0;
    model_reset();
    #12;
    chk("rst.mask",  32'(bus.active_threads), 32'h0);
    chk("rst.npc",   32'(bus.next_pc),        32'h0);
    chk("rst.load",  32'(bus.load_pc),        32'h0);
    chk("rst.depth", 32'(bus.stack_depth),    32'h0);
    chk("rst.ovf",   32'(bus.overflow),       32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (vt[i].lch) launch_blk(vt[i].tc);
      cycle($sformatf("vec%0d", i), 0, 0, 1, vt[i].br, vt[i].sy, vt[i].cond,
            vt[i].imm, vt[i].pcv, vt[i].nz);
      chk($sformatf("vec%0d.tmask", i),  32'(bus.active_threads), 32'(vt[i].e_act));
      chk($sformatf("vec%0d.tnpc", i),   32'(bus.next_pc),        32'(vt[i].e_npc));
      chk($sformatf("vec%0d.tload", i),  32'(bus.load_pc),        32'(vt[i].e_load));
      chk($sformatf("vec%0d.tdepth", i), 32'(bus.stack_depth),    32'(vt[i].e_dep));
    end

    // Nest to full, then one more divergence must overflow without branching.
    launch_blk(4);
    cycle("nest1", 0, 0, 1, 1, 0, P, 8'd10, 8'd0, {P, P, P, N});
    cycle("nest2", 0, 0, 1, 1, 0, P, 8'd10, 8'd10, {P, P, N, N});
    cycle("nest3", 0, 0, 1, 1, 0, P, 8'd10, 8'd20, {P, N, N, N});
    chk("ovf.flag",  32'(bus.overflow),       32'h1);
    chk("ovf.load",  32'(bus.load_pc),        32'h0);
    chk("ovf.mask",  32'(bus.active_threads), 32'hC);
    chk("ovf.depth", 32'(bus.stack_depth),    32'(D));
    chk("ovf.npc",   32'(bus.next_pc),        32'd21);
`ifdef SIMT_SCHED_STATS_EN
    chk("ovf.divc",  32'(bus.div_count),      32'd3);
    chk("ovf.maxd",  32'(bus.max_depth),      32'(D));
`endif
    launch_blk(4);
    chk("ovf.clr", 32'(bus.overflow), 32'h0);

    // Asynchronous reset in the middle of a divergent path.
    cycle("pre_rst", 0, 0, 1, 1, 0, P, 8'd6, 8'd80, {P, P, N, N});
    reset = 1'b0;
    #2;
    model_reset();
    chk("arst.mask",  32'(bus.active_threads), 32'h0);
    chk("arst.npc",   32'(bus.next_pc),        32'h0);
    chk("arst.load",  32'(bus.load_pc),        32'h0);
    chk("arst.depth", 32'(bus.stack_depth),    32'h0);
    chk("arst.ovf",   32'(bus.overflow),       32'h0);
    @(negedge clk);
    reset = 1'b1;
    launch_blk(2);
    chk("relaunch.mask",  32'(bus.active_threads), 32'h3);
    chk("relaunch.depth", 32'(bus.stack_depth),    32'h0);

    // Random traffic against the model.
    launch_blk(4);
    for (int i = 0; i < 600; i++) begin
      int  r;
      int  kind;
      bit  lch;
      r    = $urandom_range(0, 99);
      lch  = (r < 4);
      kind = $urandom_range(0, 9);
      cycle("rnd", lch, $urandom_range(0, T), ($urandom_range(0, 9) < 8),
            (kind < 4) || (kind == 8), (kind >= 4 && kind < 8) || (kind == 8),
            3'($urandom), 8'($urandom), A'($urandom), 12'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
